// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, owner-state encoding and requester indices
package mem_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int MAX_LOCK_DEF   = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational grant selection (lock hold, round-robin, single request)
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF,
    parameter int CW       = 3
) (
    input  owner_t        state,
    input  logic          last,
    input  logic [CW-1:0] cnt,
    input  logic [1:0]    req,
    input  logic [1:0]    lock,
    output logic [1:0]    grant
);

    logic under;
    logic keep0;
    logic keep1;

    // A locked owner keeps the port until its burst hits the limit while the other side waits
    always_comb begin
        under = cnt < CW'(MAX_LOCK);
        keep0 = (state == G0) && req[0] && lock[0] && (under || !req[1]);
        keep1 = (state == G1) && req[1] && lock[1] && (under || !req[0]);
        grant = keep0 ? 2'b01 :
                keep1 ? 2'b10 :
                &req  ? (last == REQ1 ? 2'b01 : 2'b10) :
                req[0] ? 2'b01 :
                req[1] ? 2'b10 : 2'b00;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between two requesters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    owner_t        state;
    owner_t        state_nx;
    logic          last;
    logic          last_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          rv0;
    logic          rv1;
    logic [1:0]    pick;
    logic [1:0]    grant;

    arb_pick #(
        .MAX_LOCK(MAX_LOCK),
        .CW      (CW)
    ) u_pick (
        .state(state),
        .last (last),
        .cnt  (cnt),
        .req  ({req1, req1 ? req0 : req0}),
        .lock ({lock1, lock0}),
        .grant(pick)
    );

    // Grant is suppressed in reset; the granted requester drives the RAM port, else all zero
    always_comb begin
        grant             = reset ? 2'b00 : pick;
        ack0              = grant[0];
        ack1              = grant[1];
        mem_read_address  = grant[0] ? addr0 : grant[1] ? addr1 : '0;
        mem_write_address = mem_read_address;
        mem_din           = grant[0] ? wdata0 : grant[1] ? wdata1 : '0;
        mem_write         = (grant[0] & we0) | (grant[1] & we1);
        rvalid0           = rv0 & ~reset;
        rvalid1           = rv1 & ~reset;
        rdata             = mem_dout;
    end

    // Ownership follows the lock bit; burst count grows only while the same owner stays locked
    always_comb begin
        state_nx = IDLE;
        last_nx  = last;
        cnt_nx   = '0;
        if (grant[0]) begin
            state_nx = lock0 ? G0 : IDLE;
            last_nx  = REQ0;
            cnt_nx   = (state == G0 && last == REQ0) ?
                       (cnt == CW'(MAX_LOCK) ? cnt : cnt + CW'(1)) : CW'(1);
        end else if (grant[1]) begin
            state_nx = lock1 ? G1 : IDLE;
            last_nx  = REQ1;
            cnt_nx   = (state == G1 && last == REQ1) ?
                       (cnt == CW'(MAX_LOCK) ? cnt : cnt + CW'(1)) : CW'(1);
        end
    end

    // State registers; read-valid pulses mark the cycle after a read ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= REQ1;
            cnt   <= '0;
            rv0   <= 1'b0;
            rv1   <= 1'b0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
            rv0   <= grant[0] & ~we0;
            rv1   <= grant[1] & ~we1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a reference model
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req[2];
    logic          we[2];
    logic          lock[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdata[2];
    logic          ack0, ack1, rvalid0, rvalid1, mem_write;
    logic [DW-1:0] rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_read_address, mem_write_address;

    logic          load;
    logic [AW-1:0] load_a;
    logic [DW-1:0] load_d;
    logic [DW-1:0] ram[0:255];
    logic [DW-1:0] shadow[0:255];

    int checks = 0;
    int failures = 0;

    int            own;
    int            last;
    int            cnt;
    int            g;
    logic          exp_rv[2];
    logic [DW-1:0] exp_rd;
    logic          obs_ack[2];
    logic          obs_rv[2];
    logic [DW-1:0] obs_rd;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .lock0(lock[0]), .lock1(lock[1]), .addr0(addr[0]), .addr1(addr[1]),
        .wdata0(wdata[0]), .wdata1(wdata[1]),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) ram[load_a] <= load_d;
        else if (mem_write) ram[mem_write_address] <= mem_din;
        mem_dout <= ram[mem_read_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_pick();
        if (own >= 0 && req[own] && lock[own] && (cnt < ML || !req[1-own])) return own;
        if (req[0] && req[1]) return last == 1 ? 0 : 1;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic step();
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        #4;
        g   = reset ? -1 : model_pick();
        e_a = g >= 0 ? addr[g] : '0;
        e_d = g >= 0 ? wdata[g] : '0;
        chk("ack0", ack0, g == 0);
        chk("ack1", ack1, g == 1);
        chk("mem_write", mem_write, g >= 0 ? we[g] : 1'b0);
        chk("mem_read_address", mem_read_address, e_a);
        chk("mem_write_address", mem_write_address, e_a);
        chk("mem_din", mem_din, e_d);
        chk("rvalid0", rvalid0, exp_rv[0] & ~reset);
        chk("rvalid1", rvalid1, exp_rv[1] & ~reset);
        if (!reset && (exp_rv[0] || exp_rv[1])) chk("rdata", rdata, exp_rd);
        obs_ack[0] = ack0;
        obs_ack[1] = ack1;
        obs_rv[0]  = rvalid0;
        obs_rv[1]  = rvalid1;
        obs_rd     = rdata;
        @(posedge clk);
        if (reset) begin
            own    = -1;
            last   = 1;
            cnt    = 0;
            exp_rv = '{1'b0, 1'b0};
            if (load) shadow[load_a] = load_d;
        end else begin
            exp_rv[0] = g == 0 && !we[0];
            exp_rv[1] = g == 1 && !we[1];
            if (g >= 0) begin
                exp_rd = shadow[addr[g]];
                if (we[g]) shadow[addr[g]] = wdata[g];
                cnt  = (g == last && own == g) ? (cnt < ML ? cnt + 1 : ML) : 1;
                own  = lock[g] ? g : -1;
                last = g;
            end else begin
                own = -1;
                cnt = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            req[p]   = 1'b0;
            we[p]    = 1'b0;
            lock[p]  = 1'b0;
            addr[p]  = '0;
            wdata[p] = '0;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic set_req(input int p, input logic w, input logic l, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req[p]   = 1'b1;
        we[p]    = w;
        lock[p]  = l;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    task automatic burst_test(input string tag);
        int n0;
        n0 = 0;
        set_req(0, 1'b0, 1'b1, 8'h02, '0);
        step();
        if (obs_ack[0]) n0++;
        set_req(1, 1'b0, 1'b0, 8'h03, '0);
        for (int i = 0; i < 20 && !obs_ack[1]; i++) begin
            step();
            if (obs_ack[0]) n0++;
        end
        chk({tag, "_burst_len"}, n0, ML);
        chk({tag, "_ack1_after_burst"}, obs_ack[1], 1'b1);
        req[1] = 1'b0;
    endtask

    initial begin
        idle_inputs();
        own    = -1;
        last   = 1;
        cnt    = 0;
        exp_rv = '{1'b0, 1'b0};
        exp_rd = '0;
        reset  = 1'b1;
        load   = 1'b0;
        load_a = '0;
        load_d = '0;
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b1, 8'h07, 16'h5555);
        set_req(1, 1'b1, 1'b0, 8'h08, 16'h6666);
        for (int i = 0; i < 32; i++) begin
            load   = 1'b1;
            load_a = AW'(i);
            load_d = (i == 5) ? 16'h1234 : DW'($urandom);
            step();
        end
        load = 1'b0;
        idle_inputs();
        do_reset(1);

        set_req(0, 1'b0, 1'b0, 8'h05, '0);
        step();
        chk("t1_ack0", obs_ack[0], 1'b1);
        req[0] = 1'b0;
        step();
        chk("t1_rvalid0", obs_rv[0], 1'b1);
        chk("t1_rdata", obs_rd, 16'h1234);
        chk("t1_rvalid1", obs_rv[1], 1'b0);

        do_reset(1);
        set_req(0, 1'b0, 1'b0, 8'h01, '0);
        set_req(1, 1'b0, 1'b0, 8'h02, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_alt_ack0", obs_ack[0], i % 2 == 0);
            chk("t2_alt_ack1", obs_ack[1], i % 2 == 1);
        end
        idle_inputs();
        step();

        set_req(1, 1'b1, 1'b0, 8'h10, 16'hBEEF);
        step();
        idle_inputs();
        set_req(0, 1'b0, 1'b0, 8'h10, '0);
        step();
        idle_inputs();
        step();
        chk("t3_rvalid0", obs_rv[0], 1'b1);
        chk("t3_rdata", obs_rd, 16'hBEEF);

        step();
        step();
        burst_test("t4");
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t4_lock_continue", obs_ack[0], 1'b1);
        end
        idle_inputs();
        step();
        step();
        chk("t6_idle_write", mem_write, 1'b0);
        chk("t6_idle_addr", mem_read_address, '0);
        burst_test("t6");
        idle_inputs();
        step();

        do_reset(1);
        set_req(0, 1'b0, 1'b0, 8'h03, '0);
        step();
        chk("t5_ack0", obs_ack[0], 1'b1);
        idle_inputs();
        reset = 1'b1;
        step();
        chk("t5_rvalid0_in_reset", obs_rv[0], 1'b0);
        reset = 1'b0;
        step();
        chk("t5_rvalid0_after", obs_rv[0], 1'b0);
        set_req(0, 1'b0, 1'b0, 8'h04, '0);
        set_req(1, 1'b0, 1'b0, 8'h06, '0);
        step();
        chk("t5_tie_ack0", obs_ack[0], 1'b1);
        idle_inputs();

        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 199) == 0;
            step();
            for (int p = 0; p < 2; p++) begin
                if (req[p] && obs_ack[p]) req[p] = 1'b0;
                if (!req[p]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(p, 1'($urandom_range(0, 1)), 1'b0, AW'($urandom_range(0, 31)), DW'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end
                lock[p] = $urandom_range(0, 3) != 0;
            end
        end
        reset = 1'b0;
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single synchronous-read RAM (1-cycle read latency, separate read/write address, write enable) between two requesters, e.g. CPU fetch/load-store and an I/O/DMA port. Performs one access per cycle: round-robin on contention, optional locked bursts with a starvation limit, and returns read data with a registered per-requester valid pulse. Sits between the requesters and the RAM instance at the top level.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width
- MAX_LOCK, 4, max consecutive locked grants while the other requester waits (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  access request; held until ack
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  request to keep ownership for the next access
- addr0 / addr1  in  ADDR_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- ack0 / ack1  out  1  combinational; request accepted this cycle
- rvalid0 / rvalid1  out  1  registered; rdata valid for that requester
- rdata  out  DATA_WIDTH  = mem_dout, pass-through
- mem_read_address, mem_write_address  out  ADDR_WIDTH  to RAM
- mem_write  out  1  to RAM write
- mem_din  out  DATA_WIDTH  to RAM din
- mem_dout  in  DATA_WIDTH  from RAM dout

## Operation
- State: owner FSM {IDLE, G0, G1}; last (1 bit, last granted); cnt (consecutive-grant counter, saturates at MAX_LOCK); rvalid0/1 regs.
- Grant choice each cycle, in priority order:
  - state Gn, reqn, lockn, and (cnt < MAX_LOCK or other req low) → n.
  - both req → requester ≠ last.
  - one req → that one.
  - else none.
- Granted n: ackn=1; mem_read_address = mem_write_address = addrn; mem_din = wdatan; mem_write = wen.
- No grant: all acks 0, mem_write 0, addresses and mem_din 0.
- Next state after grant n: Gn if lockn, else IDLE. last ← n. cnt ← cnt+1 (saturating) if n == last and state was Gn, else 1. No grant: state IDLE, cnt ← 0, last unchanged.
- rvalidn ← ackn & ~wen. rdata is meaningful only in a cycle where a rvalid is high.
- While reset is high: acks and mem_write forced 0.
- Reset values: state IDLE, last = 1 (requester 0 wins first tie), cnt 0, rvalid0/1 0. With reset high, every output is 0 except rdata (follows mem_dout).

## Timing
- Ack is in the same cycle as the grant decision. The write commits at the rising edge closing that cycle.
- Read latency: ack in cycle t, rvalid plus data in cycle t+1, single-cycle pulse. Reads can issue back-to-back, one per cycle.
- Write in cycle t then read of the same address in t+1 returns the new data.
- A requester never sees ack and rvalid for different accesses confused: rvalid always refers to that requester's ack one cycle earlier.
- Worst-case wait under contention: MAX_LOCK cycles.
- Reset at the edge after a read ack: rvalid stays 0, and the read is discarded.
- A req dropped before ack is legal; no state change.

## Structure
- Shared package holds DATA_WIDTH/ADDR_WIDTH defaults, the owner-state encoding (IDLE=2'b00, G0=2'b01, G1=2'b10), and requester index constants.
- One combinational sub-module `arb_pick` takes (state, last, cnt, req, lock) and returns the grant vector. Sequential state stays in mem_arbiter.
- The RAM is instantiated beside the arbiter at the top level, not inside it.

## Test plan
- Reset then req0 read addr 0x05 (RAM[5]=0x1234) → ack0 in cycle 0, rvalid0=1 and rdata=0x1234 in cycle 1, rvalid1 stays 0.
- req0 and req1 both asserted unlocked for 4 cycles → acks alternate 0,1,0,1.
- req1 write 0xBEEF to 0x10, next cycle req0 read 0x10 → rvalid0 with rdata=0xBEEF.
- lock0 held with req0 continuous, req1 asserted, MAX_LOCK=4 → 4 ack0 cycles, then ack1; with req1 low, ack0 continues indefinitely.
- Read acked, then reset asserted the next edge → rvalid0 stays 0; state returns to IDLE; first tie afterwards goes to requester 0.
- Idle cycles with no req → mem_write=0, addresses=0, acks 0, cnt cleared, so a later locked burst restarts its count at 1.
